// File: rtl/mispredict_recovery_ctrl.sv
// mispredict_recovery_ctrl
// Turns a committed branch mispredict into an ordered recovery sequence:
// flush the machine, rewrite the RAT from the committed snapshot in chunks,
// then offer the correct target to fetch over a valid/ready handshake.
// Fetch is held stalled from acceptance until the redirect is taken.
module mispredict_recovery_ctrl #(
    parameter int NREGS = 32,
    parameter int TAG_W = 3,
    parameter int CHUNK = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_mispredict,
    input  logic [TAG_W-1:0]           commit_index,
    input  logic [31:0]                commit_target,
    input  logic [NREGS*TAG_W-1:0]     commit_tags_bus,
    input  logic [NREGS-1:0]           commit_busy_bus,
    input  logic                       pc_redirect_ready,
    output logic                       flush,
    output logic                       fetch_stall,
    output logic                       rat_wr_en,
    output logic [$clog2(NREGS)-1:0]   rat_wr_base,
    output logic [CHUNK*TAG_W-1:0]     rat_wr_tags,
    output logic [CHUNK-1:0]           rat_wr_busy,
    output logic                       pc_redirect_valid,
    output logic [31:0]                pc_redirect_target,
    output logic                       recover_busy,
    output logic [TAG_W-1:0]           last_index,
    output logic [7:0]                 recover_cnt
);

    localparam int NCH   = NREGS / CHUNK;
    localparam int IDX_W = $clog2(NREGS);
    // The chunk counter has to reach NCH: that extra step is the cycle in
    // which the last chunk is on the write port and the FSM leaves RESTORE.
    localparam int K_W   = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        RESTORE  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [K_W-1:0]           k;
    logic [K_W-1:0]           k_next;
    logic                     accept;
    logic                     load_chunk;

    logic [31:0]              target_q;
    logic [NREGS*TAG_W-1:0]   tags_q;
    logic [NREGS-1:0]         busy_q;

    logic [K_W-1:0]           k_sel;
    logic [IDX_W-1:0]         chunk_base;
    logic [CHUNK*TAG_W-1:0]   chunk_tags;
    logic [CHUNK-1:0]         chunk_busy;

    // State register and chunk counter; reset abandons any recovery in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    // Next-state logic: a mispredict is only accepted from IDLE, so one that
    // arrives while a recovery is in progress is simply dropped.
    always_comb begin
        state_next = state;
        k_next     = k;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (commit_mispredict) begin
                    accept     = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = RESTORE;
                k_next     = '0;
            end
            RESTORE: begin
                if (k == K_W'(NCH)) begin
                    state_next = REDIRECT;
                    k_next     = '0;
                end else begin
                    k_next = k + K_W'(1);
                end
            end
            REDIRECT: begin
                if (pc_redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = '0;
            end
        endcase
    end

    // Snapshot capture and bookkeeping on each accepted mispredict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q    <= '0;
            tags_q      <= '0;
            busy_q      <= '0;
            last_index  <= '0;
            recover_cnt <= '0;
        end else if (accept) begin
            target_q    <= commit_target;
            tags_q      <= commit_tags_bus;
            busy_q      <= commit_busy_bus;
            last_index  <= commit_index;
            recover_cnt <= recover_cnt + 8'd1;
        end
    end

    // Select the snapshot slice for chunk k; x0 is hardwired to tag 0, not busy.
    always_comb begin
        k_sel = '0;
        if (k < K_W'(NCH)) begin
            k_sel = k;
        end
        chunk_base = IDX_W'(k_sel * CHUNK);
        chunk_tags = tags_q[k_sel * (CHUNK * TAG_W) +: CHUNK * TAG_W];
        chunk_busy = busy_q[k_sel * CHUNK +: CHUNK];
        if (k_sel == '0) begin
            chunk_tags[TAG_W-1:0] = '0;
            chunk_busy[0]         = 1'b0;
        end
    end

    assign load_chunk = (state == RESTORE) && (k != K_W'(NCH));

    // RAT write port is registered so each chunk is presented for one full
    // cycle; it is zero whenever no chunk is being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rat_wr_en   <= 1'b0;
            rat_wr_base <= '0;
            rat_wr_tags <= '0;
            rat_wr_busy <= '0;
        end else if (load_chunk) begin
            rat_wr_en   <= 1'b1;
            rat_wr_base <= chunk_base;
            rat_wr_tags <= chunk_tags;
            rat_wr_busy <= chunk_busy;
        end else begin
            rat_wr_en   <= 1'b0;
            rat_wr_base <= '0;
            rat_wr_tags <= '0;
            rat_wr_busy <= '0;
        end
    end

    assign flush              = (state == FLUSH);
    assign recover_busy       = (state != IDLE);
    assign fetch_stall        = recover_busy;
    assign pc_redirect_valid  = (state == REDIRECT);
    assign pc_redirect_target = pc_redirect_valid ? target_q : 32'd0;

endmodule
